// File: rtl/player_motion.sv
// player_motion: integrates decoded Up/Down/Left/Right levels into X/Y screen
// coordinates at a fixed movement tick, with hold-to-accelerate and edge
// clamping.
//
// Ports:
//   Clock, ResetN         clock, asynchronous active-low reset
//   Up/Down/Left/Right    decoded direction request levels (asynchronous)
//   X [X_W-1:0]           registered player X
//   Y [Y_W-1:0]           registered player Y
//   Moving                high while the last tick changed X or Y
//   Tick                  one-cycle pulse on each movement tick
//
// Build option: define PLAYER_MOTION_WRAP_EN to wrap at the screen edges
// instead of clamping. With it defined, Moving follows any non-zero request.
module player_motion #(
  parameter int TICK_DIV   = 416667,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int STEP_SLOW  = 1,
  parameter int STEP_FAST  = 4,
  parameter int HOLD_TICKS = 30
) (
  input  logic           Clock,
  input  logic           ResetN,
  input  logic           Up,
  input  logic           Down,
  input  logic           Left,
  input  logic           Right,
  output logic [X_W-1:0] X,
  output logic [Y_W-1:0] Y,
  output logic           Moving,
  output logic           Tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  // Signed, one-bit-wider constants so over/underflow is visible before clamping.
  localparam logic signed [X_W:0] XS_SLOW = (X_W+1)'(STEP_SLOW);
  localparam logic signed [X_W:0] XS_FAST = (X_W+1)'(STEP_FAST);
  localparam logic signed [Y_W:0] YS_SLOW = (Y_W+1)'(STEP_SLOW);
  localparam logic signed [Y_W:0] YS_FAST = (Y_W+1)'(STEP_FAST);
  localparam logic signed [X_W:0] XMAX_S  = (X_W+1)'(X_MAX);
  localparam logic signed [Y_W:0] YMAX_S  = (Y_W+1)'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_SLOW, S_FAST} state_t;

  // {up, down, left, right}
  logic [3:0]     dir_meta_q, dir_sync_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d, x_new;
  logic [Y_W-1:0] y_q, y_d, y_new;
  logic           moving_q, moving_d;

  logic                  tick;
  logic                  up_s, dn_s, lf_s, rt_s;
  logic                  dx_pos, dx_neg, dy_pos, dy_neg, nz;
  logic signed [X_W:0]   step_x, x_sum;
  logic signed [Y_W:0]   step_y, y_sum;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));
  assign {up_s, dn_s, lf_s, rt_s} = dir_sync_q;

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    hold_d   = hold_q;
    x_d      = x_q;
    y_d      = y_q;
    moving_d = moving_q;

    // Opposing requests cancel on their axis.
    dx_pos = rt_s & ~lf_s;
    dx_neg = lf_s & ~rt_s;
    dy_pos = dn_s & ~up_s;
    dy_neg = up_s & ~dn_s;
    nz     = dx_pos | dx_neg | dy_pos | dy_neg;

    step_x = (state_q == S_FAST) ? XS_FAST : XS_SLOW;
    step_y = (state_q == S_FAST) ? YS_FAST : YS_SLOW;

    x_sum = $signed({1'b0, x_q});
    if (dx_pos) x_sum = x_sum + step_x;
    if (dx_neg) x_sum = x_sum - step_x;
    y_sum = $signed({1'b0, y_q});
    if (dy_pos) y_sum = y_sum + step_y;
    if (dy_neg) y_sum = y_sum - step_y;

    x_new = x_sum[X_W-1:0];
    y_new = y_sum[Y_W-1:0];
`ifdef PLAYER_MOTION_WRAP_EN
    // Range is X_MAX+1 wide; modular adjust in output width is exact.
    if (x_sum < 0)           x_new = x_sum[X_W-1:0] + X_W'(X_MAX + 1);
    else if (x_sum > XMAX_S) x_new = x_sum[X_W-1:0] - X_W'(X_MAX + 1);
    if (y_sum < 0)           y_new = y_sum[Y_W-1:0] + Y_W'(Y_MAX + 1);
    else if (y_sum > YMAX_S) y_new = y_sum[Y_W-1:0] - Y_W'(Y_MAX + 1);
`else
    if (x_sum < 0)           x_new = '0;
    else if (x_sum > XMAX_S) x_new = XMAX_S[X_W-1:0];
    if (y_sum < 0)           y_new = '0;
    else if (y_sum > YMAX_S) y_new = YMAX_S[Y_W-1:0];
`endif

    if (tick) begin
      x_d = x_new;
      y_d = y_new;
`ifdef PLAYER_MOTION_WRAP_EN
      moving_d = nz;
`else
      moving_d = (x_new != x_q) || (y_new != y_q);
`endif
      if (!nz) begin
        state_d = S_IDLE;
        hold_d  = '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_d = S_SLOW;
            hold_d  = HW'(1);
          end
          S_SLOW: begin
            // Speed switch takes effect on the following tick.
            hold_d = hold_q + 1'b1;
            if (hold_q >= HW'(HOLD_TICKS - 1)) state_d = S_FAST;
          end
          default: begin
            state_d = S_FAST;
            hold_d  = hold_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      dir_meta_q <= '0;
      dir_sync_q <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      state_q    <= S_IDLE;
      x_q        <= X_W'(X_INIT);
      y_q        <= Y_W'(Y_INIT);
      moving_q   <= 1'b0;
    end else begin
      dir_meta_q <= {Up, Down, Left, Right};
      dir_sync_q <= dir_meta_q;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      moving_q   <= moving_d;
    end
  end

  assign X      = x_q;
  assign Y      = y_q;
  assign Moving = moving_q;
  assign Tick   = tick;

endmodule
